// File: rtl/dll_rst_seq.sv
// Reset sequencer for the phase-adjust DLL: pulses RST, waits for a qualified LOCKED,
// retries on timeout or lock glitch, and reports ready / sticky fail / sticky lock loss.
module dll_rst_seq #(
    parameter int unsigned RST_CYCLES    = 8,
    parameter int unsigned LOCK_TIMEOUT  = 4096,
    parameter int unsigned STABLE_CYCLES = 64,
    parameter int unsigned MAX_RETRIES   = 7,
    parameter int unsigned CW            = 13,
    parameter int unsigned RW            = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          locked,
    input  logic          restart,
    output logic          dll_rst,
    output logic          dll_ready,
    output logic          fail,
    output logic          lock_lost,
    output logic [RW-1:0] retry_cnt
);

    localparam logic [CW-1:0] RstLast     = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TimeoutLast = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] StableLast  = CW'(STABLE_CYCLES - 1);
    localparam logic [RW-1:0] MaxRetries  = RW'(MAX_RETRIES);

    typedef enum logic [2:0] {
        StHold,
        StWait,
        StStable,
        StReady,
        StFail
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] retry_q, retry_d;
    logic          lock_lost_q, lock_lost_d;
    logic          sync1_q, locked_s;
    logic          dll_rst_q, dll_ready_q, fail_q;
    logic          attempt_failed;

    // LOCKED comes from the DLL output domain; only locked_s is used past this point.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            locked_s <= 1'b0;
        end else begin
            sync1_q  <= locked;
            locked_s <= sync1_q;
        end
    end

    always_comb begin
        state_d        = state_q;
        retry_d        = retry_q;
        lock_lost_d    = lock_lost_q;
        attempt_failed = 1'b0;

        unique case (state_q)
            StHold: begin
                if (cnt_q == RstLast) state_d = StWait;
            end
            StWait: begin
                // A lock seen on the final timeout cycle takes precedence.
                if (locked_s) state_d = StStable;
                else if (cnt_q == TimeoutLast) attempt_failed = 1'b1;
            end
            StStable: begin
                if (!locked_s) attempt_failed = 1'b1;
                else if (cnt_q == StableLast) state_d = StReady;
            end
            StReady: begin
                if (!locked_s) begin
                    state_d     = StHold;
                    lock_lost_d = 1'b1;
                end
            end
            StFail: state_d = StFail;
            default: state_d = StHold;
        endcase

        if (attempt_failed) begin
            if (retry_q == MaxRetries) begin
                state_d = StFail;
            end else begin
                retry_d = retry_q + 1'b1;
                state_d = StHold;
            end
        end

        if (state_q != StReady && state_d == StReady) retry_d = '0;

        if (restart) begin
            state_d     = StHold;
            retry_d     = '0;
            lock_lost_d = 1'b0;
        end

        // READY and FAIL can last forever, so the counter freezes there rather than wrap.
        if (restart || state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q == StHold || state_q == StWait || state_q == StStable) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StHold;
            cnt_q       <= '0;
            retry_q     <= '0;
            lock_lost_q <= 1'b0;
            dll_rst_q   <= 1'b1;
            dll_ready_q <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            lock_lost_q <= lock_lost_d;
            dll_rst_q   <= (state_d == StHold) || (state_d == StFail);
            dll_ready_q <= (state_d == StReady);
            fail_q      <= (state_d == StFail);
        end
    end

    assign dll_rst   = dll_rst_q;
    assign dll_ready = dll_ready_q;
    assign fail      = fail_q;
    assign lock_lost = lock_lost_q;
    assign retry_cnt = retry_q;

endmodule

// File: tb/tb_dll_rst_seq.sv
// Scoreboard bench for dll_rst_seq: stimulus queues cycle-stamped expected outputs,
// a monitor pops and compares them on the falling edge of the matching cycle.
module tb_dll_rst_seq;

    localparam int unsigned RST_CYCLES    = 4;
    localparam int unsigned LOCK_TIMEOUT  = 32;
    localparam int unsigned STABLE_CYCLES = 8;
    localparam int unsigned MAX_RETRIES   = 2;
    localparam int unsigned CW            = 6;
    localparam int unsigned RW            = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          locked = 1'b0;
    logic          restart = 1'b0;
    logic          dll_rst, dll_ready, fail, lock_lost;
    logic [RW-1:0] retry_cnt;

    dll_rst_seq #(
        .RST_CYCLES   (RST_CYCLES),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .STABLE_CYCLES(STABLE_CYCLES),
        .MAX_RETRIES  (MAX_RETRIES),
        .CW           (CW),
        .RW           (RW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .locked   (locked),
        .restart  (restart),
        .dll_rst  (dll_rst),
        .dll_ready(dll_ready),
        .fail     (fail),
        .lock_lost(lock_lost),
        .retry_cnt(retry_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // v = {dll_rst, dll_ready, fail, lock_lost, retry_cnt[1:0]}
    typedef struct {
        int         cyc;
        logic [5:0] v;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic expect_at(input int dc, input logic r, input logic rd, input logic f,
                             input logic ll, input logic [1:0] rc, input string nm);
        exp_t e;
        int   i;
        e.cyc  = cyc + dc;
        e.v    = {r, rd, f, ll, rc};
        e.name = nm;
        i = sb.size();
        while (i > 0 && sb[i-1].cyc > e.cyc) i--;
        sb.insert(i, e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin : monitor
        exp_t       e;
        logic [5:0] act;
        forever begin
            @(negedge clk);
            #1;
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e   = sb.pop_front();
                act = {dll_rst, dll_ready, fail, lock_lost, retry_cnt};
                checks++;
                if (e.cyc != cyc) begin
                    errors++;
                    $display("FAIL %s: expected at cycle %0d, monitor reached it at %0d",
                             e.name, e.cyc, cyc);
                end else if (act !== e.v) begin
                    errors++;
                    $display("FAIL %s @cyc %0d: {rst,rdy,fail,lost,retry} got %b required %b",
                             e.name, cyc, act, e.v);
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int guard;

        // 1: power-up pulse, lock 10 cycles after dll_rst falls, ready 11 edges later.
        tick(3);
        expect_at(0, 1, 0, 0, 0, 0, "reset_state");
        expect_at(3, 1, 0, 0, 0, 0, "hold_last");
        expect_at(4, 0, 0, 0, 0, 0, "hold_end");
        rst = 1'b0;
        tick(14);
        expect_at(10, 0, 0, 0, 0, 0, "ready_early");
        expect_at(11, 0, 1, 0, 0, 0, "ready_rise");
        locked = 1'b1;
        tick(11);

        // 3: one-cycle lock drop in READY.
        tick(2);
        expect_at(2, 0, 1, 0, 0, 0, "loss_still_ready");
        expect_at(3, 1, 0, 0, 1, 0, "loss_drop");
        expect_at(6, 1, 0, 0, 1, 0, "loss_hold_last");
        expect_at(7, 0, 0, 0, 1, 0, "loss_hold_end");
        expect_at(15, 0, 0, 0, 1, 0, "relock_early");
        expect_at(16, 0, 1, 0, 1, 0, "relock_ready");
        locked = 1'b0;
        tick(1);
        locked = 1'b1;
        tick(15);

        // 4: restart (clears lock_lost), then a lock glitch at STABLE counter 5.
        expect_at(1, 1, 0, 0, 0, 0, "restart_hold");
        expect_at(5, 0, 0, 0, 0, 0, "restart_wait");
        expect_at(11, 0, 0, 0, 0, 0, "stable_cnt5");
        expect_at(12, 1, 0, 0, 0, 1, "glitch_retry");
        expect_at(16, 0, 0, 0, 0, 1, "glitch_wait");
        expect_at(24, 0, 0, 0, 0, 1, "glitch_no_ready");
        expect_at(25, 0, 1, 0, 0, 0, "glitch_relock");
        restart = 1'b1;
        tick(1);
        restart = 1'b0;
        tick(8);
        locked = 1'b0;
        tick(1);
        locked = 1'b1;
        tick(15);

        // 2: no lock at all; attempts at +1, +37, +73, FAIL at +109.
        expect_at(1, 1, 0, 0, 0, 0, "to_hold0");
        expect_at(5, 0, 0, 0, 0, 0, "wait0");
        expect_at(36, 0, 0, 0, 0, 0, "wait0_last");
        expect_at(37, 1, 0, 0, 0, 1, "retry1");
        expect_at(41, 0, 0, 0, 0, 1, "wait1");
        expect_at(73, 1, 0, 0, 0, 2, "retry2");
        expect_at(108, 0, 0, 0, 0, 2, "wait2_last");
        expect_at(109, 1, 0, 1, 0, 2, "fail");
        expect_at(150, 1, 0, 1, 0, 2, "fail_steady");
        locked  = 1'b0;
        restart = 1'b1;
        tick(1);
        restart = 1'b0;
        tick(149);

        // 5a: restart out of FAIL with lock available.
        expect_at(1, 1, 0, 0, 0, 0, "fail_restart");
        expect_at(4, 1, 0, 0, 0, 0, "fr_hold_last");
        expect_at(5, 0, 0, 0, 0, 0, "fr_wait");
        expect_at(13, 0, 0, 0, 0, 0, "fr_stable_last");
        expect_at(14, 0, 1, 0, 0, 0, "fr_ready");
        restart = 1'b1;
        locked  = 1'b1;
        tick(1);
        restart = 1'b0;
        tick(13);

        // 5b: restart on the same edge as a WAIT timeout leaves retry_cnt at 0.
        expect_at(36, 0, 0, 0, 0, 0, "tr_before");
        expect_at(37, 1, 0, 0, 0, 0, "tr_restart_wins");
        expect_at(41, 0, 0, 0, 0, 0, "tr_wait");
        locked  = 1'b0;
        restart = 1'b1;
        tick(1);
        restart = 1'b0;
        tick(35);
        restart = 1'b1;
        tick(1);
        restart = 1'b0;
        tick(4);

        // 6: asynchronous rst between edges while in WAIT.
        tick(3);
        expect_at(0, 0, 0, 0, 0, 0, "mid_wait");
        expect_at(1, 1, 0, 0, 0, 0, "async_rst");
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(negedge clk);
        tick(2);
        expect_at(3, 1, 0, 0, 0, 0, "rel_hold_last");
        expect_at(4, 0, 0, 0, 0, 0, "rel_hold_end");
        rst = 1'b0;
        tick(4);
        expect_at(10, 0, 0, 0, 0, 0, "final_early");
        expect_at(11, 0, 1, 0, 0, 0, "final_ready");
        locked = 1'b1;
        tick(12);

        guard = 0;
        while (sb.size() > 0 && guard < 50) begin
            tick(1);
            guard++;
        end
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
